// File: rtl/music_pkg.sv
// Shared definitions for the note scheduler.
//   state_t         scheduler FSM state encoding
//   MIN_HZ_DEFAULT  smallest legal hz period value (cycles)
package music_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PLAY,
      GAP,
      LIVE
   } state_t;

   localparam int unsigned MIN_HZ_DEFAULT = 20;

endpackage

// File: rtl/note_timer.sv
// 32-bit loadable down counter used for note duration and inter-note gap.
//   clock, reset   rising-edge clock, synchronous active-high reset
//   load, value    load the counter with value (takes priority over counting)
//   enable         count down one per cycle; the count holds while low
//   expire         high on the last enabled cycle of the loaded period
module note_timer (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] value,
   input  logic        enable,
   output logic        expire
);

   logic [31:0] count;

   // Saturates at zero so an over-run never wraps to a huge count.
   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= value;
      else if (enable && (count != 32'd0))
         count <= count - 32'd1;
   end

   // A period of N cycles runs N enabled cycles: N, N-1, ... 1. A zero load
   // still gives a single cycle rather than hanging.
   assign expire = enable && !load && (count <= 32'd1);

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: plays a stream of sequence notes (music box mode) with a
// fixed silent gap between them, and lets a held piano key override it.
//   clock, reset                        rising-edge clock, sync active-high reset
//   mode_box                            enables sequence playback
//   key_valid, key_hz                   live key (priority over the sequence)
//   seq_valid/hz/dur/last, seq_ready    sequence note offer and accept strobe
//   hz, play_note, wave_reset           wave generator drive (all registered)
//   busy, done                          not-IDLE flag, end-of-sequence pulse
// Optional build macro SCHED_RESUME_EN: a note interrupted by the live key
// keeps its remaining duration and resumes after release instead of being
// dropped.
module note_scheduler
   import music_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 50000,
   parameter int unsigned MIN_HZ     = MIN_HZ_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mode_box,
   input  logic        key_valid,
   input  logic [31:0] key_hz,
   input  logic        seq_valid,
   input  logic [31:0] seq_hz,
   input  logic [31:0] seq_dur,
   input  logic        seq_last,
   output logic        seq_ready,
   output logic [31:0] hz,
   output logic        play_note,
   output logic        wave_reset,
   output logic        busy,
   output logic        done
);

   state_t      state, state_n;
   logic        live, xfer, bad_note;
   logic        dur_load, dur_exp, gap_load, gap_exp;
   logic        last_q, last_n, interrupted, interrupted_n, resume_q, resume_n;
   logic [31:0] note_hz, hz_n;
   logic        seq_ready_n, play_note_n, wave_reset_n, busy_n, done_n;

   assign live     = key_valid && (key_hz >= MIN_HZ);
   assign xfer     = seq_valid && seq_ready;
   assign bad_note = (seq_dur == 32'd0) || (seq_hz < MIN_HZ);

   assign dur_load = (state == FETCH) && (state_n == PLAY);
   assign gap_load = (state != GAP) && (state_n == GAP);

   note_timer u_dur (
      .clock  (clock),
      .reset  (reset),
      .load   (dur_load),
      .value  (seq_dur),
      .enable (state == PLAY),
      .expire (dur_exp)
   );

   note_timer u_gap (
      .clock  (clock),
      .reset  (reset),
      .load   (gap_load),
      .value  (32'(GAP_CYCLES)),
      .enable (state == GAP),
      .expire (gap_exp)
   );

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (live)          state_n = LIVE;
            else if (mode_box) state_n = FETCH;
         end
         FETCH: begin
            // A note accepted on the same cycle as a key press or mode drop
            // is consumed and dropped.
            if (live)           state_n = LIVE;
            else if (!mode_box) state_n = IDLE;
            else if (xfer) begin
               if (!bad_note)     state_n = PLAY;
               else if (seq_last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         PLAY: begin
            if (live)           state_n = LIVE;
            else if (!mode_box) state_n = IDLE;
            else if (dur_exp) begin
               state_n = GAP;
               done_n  = last_q;
            end
         end
         GAP: begin
            if (live)           state_n = LIVE;
            else if (!mode_box) state_n = IDLE;
            else if (gap_exp)   state_n = last_q ? IDLE : FETCH;
         end
         LIVE: begin
            // With playback switched off there is no sequence to go back to.
            if (!live) begin
               if (!mode_box)        state_n = IDLE;
               else if (resume_q)    state_n = PLAY;
               else if (interrupted) state_n = GAP;
               else                  state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Remembers whether LIVE was entered from an active sequence.
      interrupted_n = (state_n == LIVE) &&
                      ((state == LIVE) ? interrupted : (state != IDLE));

`ifdef SCHED_RESUME_EN
      // A note cut on its final counted cycle has nothing left to resume.
      resume_n = (state_n == LIVE) &&
                 (((state == PLAY) && !dur_exp) || ((state == LIVE) && resume_q));
`else
      resume_n = 1'b0;
`endif

      if (dur_load)                                  last_n = seq_last;
      else if ((state_n == IDLE) || (state_n == FETCH)) last_n = 1'b0;
      else                                           last_n = last_q;

      busy_n      = (state_n != IDLE);
      play_note_n = (state_n == PLAY) || (state_n == LIVE);
      seq_ready_n = (state_n == FETCH) && !key_valid;

      if (state_n == LIVE)      hz_n = key_hz;
      else if (dur_load)        hz_n = seq_hz;
      else if (state_n == PLAY) hz_n = note_hz;
      else                      hz_n = '0;

      // In LIVE the hz register holds last cycle's key_hz, so a mismatch
      // means the key period just changed.
      wave_reset_n = ((state_n == PLAY) && (state != PLAY)) ||
                     ((state_n == LIVE) && ((state != LIVE) || (key_hz != hz)));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         hz          <= '0;
         play_note   <= 1'b0;
         wave_reset  <= 1'b0;
         seq_ready   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         note_hz     <= '0;
         last_q      <= 1'b0;
         interrupted <= 1'b0;
         resume_q    <= 1'b0;
      end else begin
         state       <= state_n;
         hz          <= hz_n;
         play_note   <= play_note_n;
         wave_reset  <= wave_reset_n;
         seq_ready   <= seq_ready_n;
         busy        <= busy_n;
         done        <= done_n;
         last_q      <= last_n;
         interrupted <= interrupted_n;
         resume_q    <= resume_n;
         if (dur_load) note_hz <= seq_hz;
      end
   end

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler. The monitor splits the output stream
// into segments of constant {busy, play_note, seq_ready, hz}, counting length,
// wave_reset cycles and done cycles per segment, and checks each closed
// segment against the hand-computed expectation queue.
module tb_note_scheduler;

   localparam int GAP = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mode_box = 1'b0;
   logic        key_valid = 1'b0;
   logic [31:0] key_hz = '0;
   logic        seq_valid = 1'b0;
   logic [31:0] seq_hz = '0;
   logic [31:0] seq_dur = '0;
   logic        seq_last = 1'b0;
   logic        seq_ready, play_note, wave_reset, busy, done;
   logic [31:0] hz;

   always #5 clock = ~clock;

   note_scheduler #(.GAP_CYCLES(GAP), .MIN_HZ(20)) dut (
      .clock      (clock),
      .reset      (reset),
      .mode_box   (mode_box),
      .key_valid  (key_valid),
      .key_hz     (key_hz),
      .seq_valid  (seq_valid),
      .seq_hz     (seq_hz),
      .seq_dur    (seq_dur),
      .seq_last   (seq_last),
      .seq_ready  (seq_ready),
      .hz         (hz),
      .play_note  (play_note),
      .wave_reset (wave_reset),
      .busy       (busy),
      .done       (done)
   );

   typedef struct packed {
      logic [31:0] hz;
      logic [31:0] dur;
      logic        last;
   } note_t;

   typedef struct packed {
      logic        busy;
      logic        play;
      logic        rdy;
      logic [31:0] hz;
      int          len;   // -1: length not checked
      int          wr;
      int          dn;
   } seg_t;

   note_t nq[$];
   seg_t  exp_q[$];
   int    n_chk = 0, n_pass = 0, seg_idx = 0;
   string cur_test = "init";
   logic  mon_en = 1'b0, flush = 1'b0;

   function automatic void push_note(logic [31:0] h, logic [31:0] d, logic l);
      note_t n;
      n.hz = h; n.dur = d; n.last = l;
      nq.push_back(n);
   endfunction

   function automatic void exp_seg(logic b, logic p, logic r, logic [31:0] h,
                                   int len, int wr, int dn);
      seg_t s;
      s.busy = b; s.play = p; s.rdy = r; s.hz = h; s.len = len; s.wr = wr; s.dn = dn;
      exp_q.push_back(s);
   endfunction

   function automatic void e_idle(int len);            exp_seg(0, 0, 0, 0, len, 0, 0);  endfunction
   function automatic void e_fetch(int len);           exp_seg(1, 0, 1, 0, len, 0, 0);  endfunction
   function automatic void e_gap(int len, int dn);     exp_seg(1, 0, 0, 0, len, 0, dn); endfunction
   function automatic void e_snd(logic [31:0] h, int len); exp_seg(1, 1, 0, h, len, 1, 0); endfunction

   task automatic check_seg(input seg_t got);
      seg_t e;
      n_chk++;
      seg_idx++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s_seg%0d: got busy=%0b play=%0b rdy=%0b hz=%0d len=%0d, required no segment",
                  cur_test, seg_idx, got.busy, got.play, got.rdy, got.hz, got.len);
         return;
      end
      e = exp_q.pop_front();
      if (got.busy !== e.busy || got.play !== e.play || got.rdy !== e.rdy || got.hz !== e.hz ||
          (e.len >= 0 && got.len != e.len) || got.wr != e.wr || got.dn != e.dn)
         $display("FAIL %s_seg%0d: got busy=%0b play=%0b rdy=%0b hz=%0d len=%0d wr=%0d done=%0d, required busy=%0b play=%0b rdy=%0b hz=%0d len=%0d wr=%0d done=%0d",
                  cur_test, seg_idx, got.busy, got.play, got.rdy, got.hz, got.len, got.wr, got.dn,
                  e.busy, e.play, e.rdy, e.hz, e.len, e.wr, e.dn);
      else
         n_pass++;
   endtask

   // Sequence source: offers the head of nq, pops it on a handshake.
   initial forever begin
      @(posedge clock);
      if (seq_valid && seq_ready && nq.size() > 0) void'(nq.pop_front());
      #1;
      if (nq.size() > 0) begin
         seq_valid = 1'b1;
         seq_hz    = nq[0].hz;
         seq_dur   = nq[0].dur;
         seq_last  = nq[0].last;
      end else begin
         seq_valid = 1'b0;
      end
   end

   // Monitor: closes a segment whenever the signature changes or on flush.
   initial begin
      seg_t cur;
      logic have;
      have = 1'b0;
      cur  = '0;
      forever begin
         @(negedge clock);
         if (!mon_en) begin
            have = 1'b0;
         end else begin
            if (have && (flush || busy !== cur.busy || play_note !== cur.play ||
                         seq_ready !== cur.rdy || hz !== cur.hz)) begin
               check_seg(cur);
               have = 1'b0;
            end
            if (!have) begin
               cur.busy = busy; cur.play = play_note; cur.rdy = seq_ready; cur.hz = hz;
               cur.len = 0; cur.wr = 0; cur.dn = 0;
               have = 1'b1;
            end
            cur.len++;
            if (wave_reset) cur.wr++;
            if (done) cur.dn++;
         end
      end
   end

   task automatic start_test(string name);
      @(posedge clock);
      #1;
      mon_en = 1'b0; reset = 1'b1; mode_box = 1'b0; key_valid = 1'b0; key_hz = '0;
      nq.delete();
      exp_q.delete();
      cur_test = name;
      seg_idx  = 0;
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic end_test();
      @(posedge clock);
      #1 flush = 1'b1;
      @(negedge clock);
      #1 flush = 1'b0;
      mon_en = 1'b0;
      n_chk++;
      if (exp_q.size() != 0) begin
         $display("FAIL %s_missing: got %0d segments outstanding, required 0", cur_test, exp_q.size());
         exp_q.delete();
      end else begin
         n_pass++;
      end
   endtask

   // Waits for done, then lets the final GAP run out before stopping playback.
   task automatic wait_done_then_stop();
      int k;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!done && k < 300);
      n_chk++;
      if (!done) $display("FAIL %s_done_timeout: got no done in %0d cycles, required a done pulse", cur_test, k);
      else       n_pass++;
      repeat (GAP) @(posedge clock);
      #1 mode_box = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, required finish");
      $fatal(1);
   end

   initial begin
      // Two-note sequence with gap and done.
      start_test("seq2");
      push_note(1000, 10, 0);
      push_note(2000, 5, 1);
      mode_box = 1'b1;
      e_idle(1); e_fetch(1); e_snd(1000, 10); e_gap(GAP, 0); e_fetch(1);
      e_snd(2000, 5); e_gap(GAP, 1); e_idle(-1);
      wait_done_then_stop();
      end_test();

      // Live key interrupts the third cycle of a 10-cycle note.
      start_test("live_int");
      push_note(1000, 10, 0);
      push_note(2000, 2, 1);
      mode_box = 1'b1;
      e_idle(1); e_fetch(1); e_snd(1000, 3); e_snd(500, 6);
`ifdef SCHED_RESUME_EN
      e_snd(1000, 7);
`endif
      e_gap(GAP, 0); e_fetch(1); e_snd(2000, 2); e_gap(GAP, 1); e_idle(-1);
      repeat (4) @(posedge clock);
      #1 key_valid = 1'b1; key_hz = 500;
      repeat (6) @(posedge clock);
      #1 key_valid = 1'b0;
      wait_done_then_stop();
      end_test();

      // Zero-duration note dropped, next note plays.
      start_test("dur0");
      push_note(1000, 0, 0);
      push_note(800, 3, 1);
      mode_box = 1'b1;
      e_idle(1); e_fetch(2); e_snd(800, 3); e_gap(GAP, 1); e_idle(-1);
      wait_done_then_stop();
      end_test();

      // Key below MIN_HZ is ignored in IDLE.
      start_test("key_low");
      key_valid = 1'b1; key_hz = 10;
      e_idle(21);
      repeat (20) @(posedge clock);
      end_test();

      // Key at exactly MIN_HZ plays, period change re-triggers, release idles.
      start_test("key_min");
      key_valid = 1'b1; key_hz = 20;
      e_idle(1); e_snd(20, 3); e_snd(21, 2); e_idle(-1);
      repeat (3) @(posedge clock);
      #1 key_hz = 21;
      repeat (2) @(posedge clock);
      #1 key_valid = 1'b0;
      repeat (3) @(posedge clock);
      end_test();

      // Reset mid-note silences everything on the next cycle.
      start_test("rst_mid");
      push_note(1000, 10, 1);
      mode_box = 1'b1;
      e_idle(1); e_fetch(1); e_snd(1000, 3); e_idle(-1);
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0; mode_box = 1'b0;
      repeat (3) @(posedge clock);
      end_test();

      // FETCH with nothing offered holds ready and busy.
      start_test("fetch_wait");
      mode_box = 1'b1;
      e_idle(1); e_fetch(100);
      repeat (100) @(posedge clock);
      end_test();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 50000, giving silent cycles between consecutive sequence notes.
REQ-002 The block SHALL have parameter MIN_HZ, default 20, giving the smallest legal hz period value.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port mode_box, input, 1, which enables sequence (music box) playback.
REQ-006 The block SHALL have port key_valid, input, 1, which is high while a piano key is held.
REQ-007 The block SHALL have port key_hz, input, 32, the live key period in cycles.
REQ-008 The block SHALL have ports seq_valid (input, 1), seq_hz (input, 32), seq_dur (input, 32, duration in cycles) and seq_last (input, 1), which together form the sequence note offer.
REQ-009 The block SHALL have port seq_ready, output, 1, the sequence accept strobe.
REQ-010 The block SHALL have ports hz (output, 32), play_note (output, 1) and wave_reset (output, 1), which drive the wave generator.
REQ-011 The block SHALL have ports busy (output, 1), high in any state but IDLE, and done (output, 1), a one-cycle pulse at the end of the sequence.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, PLAY, GAP and LIVE, and all outputs SHALL be registered.
REQ-013 The live key SHALL take priority: key_valid with key_hz>=MIN_HZ in any state moves the FSM to LIVE next cycle.
REQ-014 IDLE SHALL go to FETCH when mode_box=1 and no live key is present.
REQ-015 seq_ready SHALL be 1 only in FETCH with key_valid=0, and a transfer SHALL occur when seq_valid and seq_ready are both 1 on the same cycle.
REQ-016 An accepted note with seq_dur=0 or seq_hz<MIN_HZ SHALL be discarded; the FSM stays in FETCH, and if seq_last=1 it pulses done and goes to IDLE.
REQ-017 A valid accepted note SHALL go to PLAY: hz=seq_hz and play_note=1 for exactly seq_dur cycles, and wave_reset=1 on the first PLAY cycle only.
REQ-018 At PLAY expiry the FSM SHALL go to GAP; if the note was last, done pulses on the first GAP cycle.
REQ-019 GAP SHALL hold play_note=0 and hz=0 for exactly GAP_CYCLES cycles, then go to FETCH, or to IDLE if the note was last or mode_box=0.
REQ-020 In LIVE, hz SHALL equal key_hz delayed one cycle, play_note=1, and wave_reset SHALL pulse on LIVE entry and on any key_hz change.
REQ-021 On key release, LIVE SHALL go to GAP if a sequence was interrupted, else to IDLE.
REQ-022 If mode_box falls in FETCH, PLAY or GAP, the FSM SHALL go to IDLE next cycle and discard the current note.
REQ-023 play_note=0 SHALL always imply hz=0.
REQ-024 The duration counter SHALL be 32-bit unsigned, and seq_dur=32'hFFFFFFFF SHALL play without wrap.

Reset
REQ-025 Under reset the block SHALL be in IDLE with hz=0, play_note=0, wave_reset=0, seq_ready=0, busy=0, done=0 and counters=0.
REQ-026 Reset SHALL take precedence over every other input and aborts any note mid-play.

Configuration
REQ-027 With SCHED_RESUME_EN defined, a PLAY note interrupted by LIVE SHALL keep its remaining duration and resume in PLAY after key release, with a wave_reset pulse and without a GAP.
REQ-028 Without SCHED_RESUME_EN, an interrupted note SHALL be discarded and key release goes to GAP, then FETCH.

Structure
REQ-029 Shared package music_pkg SHALL hold the state enumeration and the MIN_HZ default constant.
REQ-030 Sub-module note_timer SHALL be a 32-bit loadable down counter with load, enable, hold and expire pulse, instanced twice (duration, gap).

Verification
REQ-031 The bench SHALL cover: reset, mode_box=1, notes (hz=1000,dur=10),(hz=2000,dur=5,last), GAP_CYCLES=4 -> play_note high 10 cycles, low 4, high 5, done pulse, then IDLE.
REQ-032 The bench SHALL cover: key_valid with key_hz=500 during PLAY at cycle 3 of dur=10 -> play_note stays high, hz=500 next cycle, wave_reset pulse; resume 7 cycles with SCHED_RESUME_EN, next note without.
REQ-033 The bench SHALL cover: a note with seq_dur=0, then (hz=800,dur=3) -> first note discarded with no play_note, second plays 3 cycles.
REQ-034 The bench SHALL cover: key_hz=10 (below MIN_HZ) with key_valid=1 in IDLE -> stays IDLE, play_note=0.
REQ-035 The bench SHALL cover: reset asserted mid-PLAY -> next cycle all outputs 0, state IDLE.
REQ-036 The bench SHALL cover: seq_valid held 0 in FETCH for 100 cycles -> seq_ready stays 1, play_note 0, busy 1.
